// File: rtl/text_renderer.sv
// Font-ROM glyph renderer: two-stage pixel pipeline that merges text over
// the game background, with optional frame-rate blinking and aligned syncs.
module text_renderer #(
   parameter logic [11:0] FG_COLOR     = 12'hFFF,
   parameter int          BLINK_FRAMES = 30
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p_tick,
   input  logic        frame_tick,
   input  logic        blink_en,
   input  logic        video_on,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        text_on,
   input  logic [10:0] rom_addr,
   input  logic [2:0]  bit_addr,
   input  logic [11:0] game_rgb,
   output logic [10:0] font_addr,
   input  logic [7:0]  font_data,
   output logic [11:0] rgb,
   output logic        hsync_out,
   output logic        vsync_out
);

   localparam int CNT_W = $clog2(BLINK_FRAMES + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLINK_FRAMES - 1);

   logic [2:0]       bit_addr_s1;
   logic             text_on_s1;
   logic             video_on_s1;
   logic             hsync_s1;
   logic             vsync_s1;
   logic [11:0]      game_rgb_s1;
   logic [CNT_W-1:0] blink_cnt;
   logic             visible;
   logic             pix;
   logic [11:0]      rgb_next;

   // bit 7 of the ROM row is the leftmost column, so column c maps to 7-c
   always_comb begin
      pix      = font_data[~bit_addr_s1];
      rgb_next = game_rgb_s1;
      if (!video_on_s1)
         rgb_next = '0;
      else if (text_on_s1 && pix && visible)
         rgb_next = FG_COLOR;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         font_addr   <= '0;
         bit_addr_s1 <= '0;
         text_on_s1  <= 1'b0;
         video_on_s1 <= 1'b0;
         hsync_s1    <= 1'b1;
         vsync_s1    <= 1'b1;
         game_rgb_s1 <= '0;
         rgb         <= '0;
         hsync_out   <= 1'b1;
         vsync_out   <= 1'b1;
      end else if (p_tick) begin
         font_addr   <= rom_addr;
         bit_addr_s1 <= bit_addr;
         text_on_s1  <= text_on;
         video_on_s1 <= video_on;
         hsync_s1    <= hsync_in;
         vsync_s1    <= vsync_in;
         game_rgb_s1 <= game_rgb;
         rgb         <= rgb_next;
         hsync_out   <= hsync_s1;
         vsync_out   <= vsync_s1;
      end
   end

   // blink state runs every clk so frame_tick is never missed between pixels
   always_ff @(posedge clk) begin
      if (reset || !blink_en) begin
         blink_cnt <= '0;
         visible   <= 1'b1;
      end else if (frame_tick) begin
         if (blink_cnt == LAST_CNT) begin
            blink_cnt <= '0;
            visible   <= ~visible;
         end else begin
            blink_cnt <= blink_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_text_renderer.sv
// Randomised and directed bench for text_renderer against a pixel-queue
// reference model with a frame-count based blink model.
module tb_text_renderer;

   localparam int          BF = 3;
   localparam logic [11:0] FG = 12'hFFF;

   typedef struct packed {
      logic        v;
      logic        t;
      logic [10:0] a;
      logic [2:0]  b;
      logic [11:0] g;
      logic        hs;
      logic        vs;
   } px_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        p_tick;
   logic        frame_tick;
   logic        blink_en;
   logic        video_on;
   logic        hsync_in;
   logic        vsync_in;
   logic        text_on;
   logic [10:0] rom_addr;
   logic [2:0]  bit_addr;
   logic [11:0] game_rgb;
   logic [10:0] font_addr;
   logic [7:0]  font_data = 8'h00;
   logic [11:0] rgb;
   logic        hsync_out;
   logic        vsync_out;

   int checks   = 0;
   int failures = 0;
   int fcnt     = 0;

   px_t         prev;
   logic [11:0] e_rgb = '0;
   logic        e_hs  = 1'b1;
   logic        e_vs  = 1'b1;
   logic [10:0] e_fa  = '0;

   always #5 clk = ~clk;

   text_renderer #(.FG_COLOR(FG), .BLINK_FRAMES(BF)) dut (
      .clk        (clk),
      .reset      (reset),
      .p_tick     (p_tick),
      .frame_tick (frame_tick),
      .blink_en   (blink_en),
      .video_on   (video_on),
      .hsync_in   (hsync_in),
      .vsync_in   (vsync_in),
      .text_on    (text_on),
      .rom_addr   (rom_addr),
      .bit_addr   (bit_addr),
      .game_rgb   (game_rgb),
      .font_addr  (font_addr),
      .font_data  (font_data),
      .rgb        (rgb),
      .hsync_out  (hsync_out),
      .vsync_out  (vsync_out)
   );

   function automatic logic [7:0] rom(input logic [10:0] a);
      logic [7:0] r;
      if (a == 11'h463)
         r = 8'hFE;
      else
         r = (a[7:0] * 8'd37) ^ {5'b0, a[10:8]};
      return r;
   endfunction

   always @(posedge clk) font_data <= rom(font_addr);

   function automatic logic [11:0] model_rgb(input px_t p, input logic vis);
      logic [7:0] row;
      row = rom(p.a);
      if (!p.v)
         return 12'h000;
      if (p.t && row[7 - int'(p.b)] && vis)
         return FG;
      return p.g;
   endfunction

   task automatic check(input string tag, input logic [31:0] o,
                        input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic step(input logic pt, input logic ft);
      px_t  cur;
      logic vis;
      p_tick     = pt;
      frame_tick = ft;
      @(posedge clk);
      cur = {video_on, text_on, rom_addr, bit_addr, game_rgb,
             hsync_in, vsync_in};
      if (reset) begin
         prev  = {1'b0, 1'b0, 11'd0, 3'd0, 12'd0, 1'b1, 1'b1};
         e_rgb = '0;
         e_hs  = 1'b1;
         e_vs  = 1'b1;
         e_fa  = '0;
         fcnt  = 0;
      end else begin
         vis = ((fcnt / BF) % 2) == 0;
         if (pt) begin
            e_rgb = model_rgb(prev, vis);
            e_hs  = prev.hs;
            e_vs  = prev.vs;
            e_fa  = cur.a;
            prev  = cur;
         end
         if (!blink_en)
            fcnt = 0;
         else if (ft)
            fcnt++;
      end
      #1;
      check("rgb", 32'(rgb), 32'(e_rgb));
      check("hsync", 32'(hsync_out), 32'(e_hs));
      check("vsync", 32'(vsync_out), 32'(e_vs));
      check("font_addr", 32'(font_addr), 32'(e_fa));
      p_tick     = 1'b0;
      frame_tick = 1'b0;
   endtask

   task automatic set_px(input logic v, input logic t, input logic [10:0] a,
                         input logic [2:0] b, input logic [11:0] g,
                         input logic hs, input logic vs);
      video_on = v;
      text_on  = t;
      rom_addr = a;
      bit_addr = b;
      game_rgb = g;
      hsync_in = hs;
      vsync_in = vs;
   endtask

   task automatic px(input logic v, input logic t, input logic [10:0] a,
                     input logic [2:0] b, input logic [11:0] g,
                     input logic hs, input logic vs);
      set_px(v, t, a, b, g, hs, vs);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
   endtask

   task automatic rnd_inputs();
      logic [10:0] a;
      a = ($urandom_range(0, 2) == 0) ? 11'h463 : 11'($urandom);
      set_px($urandom_range(0, 3) != 0, 1'($urandom), a, 3'($urandom),
             12'($urandom), 1'($urandom), 1'($urandom));
   endtask

   initial begin
      prev       = {1'b0, 1'b0, 11'd0, 3'd0, 12'd0, 1'b1, 1'b1};
      p_tick     = 1'b0;
      frame_tick = 1'b0;
      blink_en   = 1'b0;
      reset      = 1'b1;
      set_px(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1);

      // reset held with random inputs
      for (int i = 0; i < 3; i++) begin
         rnd_inputs();
         step(1'($urandom), 1'($urandom));
      end
      reset = 1'b0;

      // glyph sweep across 'F' row 3
      for (int c = 0; c < 8; c++)
         px(1'b1, 1'b1, 11'h463, 3'(c), 12'h0A0, 1'b1, 1'b1);

      // blanking, passthrough and sync edges
      px(1'b0, 1'b1, 11'h463, 3'd0, 12'h0A0, 1'b0, 1'b1);
      px(1'b1, 1'b0, 11'h463, 3'd0, 12'h5C3, 1'b1, 1'b0);
      px(1'b1, 1'b0, 11'h123, 3'd4, 12'h9E1, 1'b0, 1'b0);
      px(1'b1, 1'b1, 11'h463, 3'd7, 12'h222, 1'b1, 1'b1);
      px(1'b1, 1'b1, 11'h463, 3'd1, 12'h333, 1'b1, 1'b1);

      // hold: inputs change with p_tick low
      for (int i = 0; i < 5; i++) begin
         rnd_inputs();
         step(1'b0, 1'b0);
      end

      // blink over 7 frames on a lit pixel
      blink_en = 1'b1;
      for (int f = 0; f < 7; f++) begin
         step(1'b0, 1'b1);
         px(1'b1, 1'b1, 11'h463, 3'd2, 12'h0A0, 1'b1, 1'b1);
         px(1'b1, 1'b1, 11'h463, 3'd2, 12'h0A0, 1'b1, 1'b1);
      end

      // frame_tick coincident with p_tick, then disable mid-count
      set_px(1'b1, 1'b1, 11'h463, 3'd3, 12'h0A0, 1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      blink_en = 1'b0;
      step(1'b0, 1'b1);
      px(1'b1, 1'b1, 11'h463, 3'd3, 12'h0A0, 1'b1, 1'b1);
      px(1'b1, 1'b1, 11'h463, 3'd3, 12'h0A0, 1'b1, 1'b1);
      blink_en = 1'b1;
      for (int f = 0; f < 4; f++) begin
         step(1'b0, 1'b1);
         px(1'b1, 1'b1, 11'h463, 3'd4, 12'h0A0, 1'b1, 1'b1);
         px(1'b1, 1'b1, 11'h463, 3'd4, 12'h0A0, 1'b1, 1'b1);
      end

      // randomised traffic with a mid-stream reset
      for (int i = 0; i < 300; i++) begin
         if (i == 150) reset = 1'b1;
         if (i == 151) reset = 1'b0;
         if ($urandom_range(0, 19) == 0) blink_en = ~blink_en;
         rnd_inputs();
         step(1'b1, $urandom_range(0, 3) == 0);
         for (int g = $urandom_range(1, 3); g > 0; g--)
            step(1'b0, $urandom_range(0, 5) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
